// File: rtl/debug_view_sequencer_pkg.sv
// Shared types for the debug view sequencer: display mode and freeze FSM states.
package debug_view_sequencer_pkg;

    typedef enum logic {
        VIEW_MANUAL = 1'b0,
        VIEW_AUTO   = 1'b1
    } view_mode_t;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } view_state_t;

    localparam int unsigned HIT_CNT_W = 16;

endpackage

// File: rtl/debug_view_sequencer_scroll_timer.sv
// Auto-scroll divider: counts 0..SCROLL_DIV-1 while enabled and emits a one-cycle tick on terminal count.
module scroll_timer #(
    parameter  int unsigned SCROLL_DIV = 24'd5000000,
    localparam int unsigned CW         = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1
) (
    input  logic clock,
    input  logic reset_L,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [CW-1:0] cnt;

    always_comb tick = en && !clr && (cnt == CW'(SCROLL_DIV - 1));

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debug_view_sequencer.sv
// Shows one pair of debug channels at a time (manual or auto-scrolled), with a
// breakpoint-triggered snapshot that freezes the view until released.
module debug_view_sequencer
    import debug_view_sequencer_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 8,
    parameter  int unsigned WIDTH      = 16,
    parameter  int unsigned SCROLL_DIV = 24'd5000000,
    localparam int unsigned PW         = (NUM_CH / 2 > 1) ? $clog2(NUM_CH / 2) : 1
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic [NUM_CH*WIDTH-1:0]  ch_data,
    input  view_mode_t               mode,
    input  logic [PW-1:0]            sel_pair,
    input  logic [WIDTH-1:0]         pc,
    input  logic                     trig_en,
    input  logic [WIDTH-1:0]         trig_addr,
    input  logic                     freeze_clr,
    output logic [WIDTH-1:0]         disp1,
    output logic [WIDTH-1:0]         disp0,
    output logic [PW-1:0]            pair_idx,
    output logic                     frozen,
    output logic [HIT_CNT_W-1:0]     hit_count
);

    localparam int unsigned NPAIR = NUM_CH / 2;
    localparam int unsigned IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    view_state_t      state, state_next;
    logic             hit, tick, capture;
    logic [PW-1:0]    pair_next;
    logic [IW-1:0]    even_idx, odd_idx;
    logic [WIDTH-1:0] snapshot  [NUM_CH];
    logic [WIDTH-1:0] snap_next [NUM_CH];
    logic [WIDTH-1:0] view      [NUM_CH];

    always_comb hit = trig_en && (pc == trig_addr);

    scroll_timer #(.SCROLL_DIV(SCROLL_DIV)) u_scroll (
        .clock   (clock),
        .reset_L (reset_L),
        .en      (mode == VIEW_AUTO),
        .clr     (mode == VIEW_MANUAL),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= LIVE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LIVE:    if (hit && !freeze_clr) state_next = FROZEN;
            FROZEN:  if (freeze_clr)         state_next = LIVE;
            default: state_next = LIVE;
        endcase
    end

    always_comb begin
        capture = (state == LIVE) && (state_next == FROZEN);
        frozen  = (state == FROZEN);
    end

    // Display source follows the next state so disp* always agree with frozen on the same edge.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            snap_next[k] = capture ? ch_data[k*WIDTH +: WIDTH] : snapshot[k];
            view[k]      = (state_next == FROZEN) ? snap_next[k] : ch_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        pair_next = pair_idx;
        if (mode == VIEW_MANUAL) begin
            pair_next = (32'(sel_pair) >= NPAIR) ? PW'(NPAIR - 1) : sel_pair;
        end else if (tick) begin
            pair_next = (32'(pair_idx) >= NPAIR - 1) ? '0 : pair_idx + 1'b1;
        end
        even_idx = IW'(2 * 32'(pair_next));
        odd_idx  = IW'(2 * 32'(pair_next) + 1);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned k = 0; k < NUM_CH; k++) snapshot[k] <= '0;
            disp1     <= '0;
            disp0     <= '0;
            pair_idx  <= '0;
            hit_count <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) snapshot[k] <= snap_next[k];
            disp1    <= view[odd_idx];
            disp0    <= view[even_idx];
            pair_idx <= pair_next;
            if (hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_debug_view_sequencer.sv
// Directed bench for debug_view_sequencer with NUM_CH=8, WIDTH=16, SCROLL_DIV=4.
module tb_debug_view_sequencer;
    import debug_view_sequencer_pkg::*;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned PW     = 2;

    logic                    clock = 1'b0;
    logic                    reset_L;
    logic [NUM_CH*WIDTH-1:0] ch_data;
    view_mode_t              mode;
    logic [PW-1:0]           sel_pair;
    logic [WIDTH-1:0]        pc;
    logic                    trig_en;
    logic [WIDTH-1:0]        trig_addr;
    logic                    freeze_clr;
    logic [WIDTH-1:0]        disp1, disp0;
    logic [PW-1:0]           pair_idx;
    logic                    frozen;
    logic [15:0]             hit_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    debug_view_sequencer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SCROLL_DIV(4)) dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .ch_data    (ch_data),
        .mode       (mode),
        .sel_pair   (sel_pair),
        .pc         (pc),
        .trig_en    (trig_en),
        .trig_addr  (trig_addr),
        .freeze_clr (freeze_clr),
        .disp1      (disp1),
        .disp0      (disp0),
        .pair_idx   (pair_idx),
        .frozen     (frozen),
        .hit_count  (hit_count)
    );

    always #5 clock = ~clock;

    function automatic logic [NUM_CH*WIDTH-1:0] ramp_channels();
        logic [NUM_CH*WIDTH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k*WIDTH +: WIDTH] = 16'h1000 + 16'(k);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_L    = 1'b0;
        ch_data    = ramp_channels();
        mode       = VIEW_MANUAL;
        sel_pair   = '0;
        pc         = '0;
        trig_en    = 1'b0;
        trig_addr  = 16'h0040;
        freeze_clr = 1'b0;

        #3;
        chk("rst_disp1", 32'(disp1), 32'h0);
        chk("rst_disp0", 32'(disp0), 32'h0);
        chk("rst_pair", 32'(pair_idx), 32'h0);
        chk("rst_frozen", 32'(frozen), 32'h0);
        chk("rst_hits", 32'(hit_count), 32'h0);

        tick(2);
        reset_L = 1'b1;

        // Manual select of pair 2
        sel_pair = 2'd2;
        tick(1);
        chk("man_disp1", 32'(disp1), 32'h1005);
        chk("man_disp0", 32'(disp0), 32'h1004);
        chk("man_pair", 32'(pair_idx), 32'd2);

        // Auto scroll from pair 3
        sel_pair = 2'd3;
        tick(1);
        chk("man_pair3", 32'(pair_idx), 32'd3);
        mode = VIEW_AUTO;
        tick(3);
        chk("auto_hold3", 32'(pair_idx), 32'd3);
        tick(1);
        chk("auto_wrap0", 32'(pair_idx), 32'd0);
        chk("auto_disp1", 32'(disp1), 32'h1001);
        chk("auto_disp0", 32'(disp0), 32'h1000);
        tick(3);
        chk("auto_hold0", 32'(pair_idx), 32'd0);
        tick(1);
        chk("auto_pair1", 32'(pair_idx), 32'd1);
        chk("auto_p1_disp1", 32'(disp1), 32'h1003);

        // Back to manual takes sel_pair on the next cycle
        mode = VIEW_MANUAL;
        sel_pair = 2'd2;
        tick(1);
        chk("to_man_pair", 32'(pair_idx), 32'd2);

        // Breakpoint capture
        trig_en = 1'b1;
        pc = 16'h0040;
        tick(1);
        chk("bp_frozen", 32'(frozen), 32'h1);
        chk("bp_hits", 32'(hit_count), 32'd1);
        chk("bp_disp1", 32'(disp1), 32'h1005);
        pc = 16'h0000;
        ch_data = '1;
        tick(1);
        chk("frz_frozen", 32'(frozen), 32'h1);
        chk("frz_disp1", 32'(disp1), 32'h1005);
        chk("frz_disp0", 32'(disp0), 32'h1004);
        chk("frz_hits", 32'(hit_count), 32'd1);
        sel_pair = 2'd0;
        tick(1);
        chk("frz_sel0_disp0", 32'(disp0), 32'h1000);
        chk("frz_sel0_disp1", 32'(disp1), 32'h1001);

        // Hit while frozen: counted, no recapture
        pc = 16'h0040;
        tick(1);
        pc = 16'h0000;
        chk("frz_hit_count", 32'(hit_count), 32'd2);
        chk("frz_hit_frozen", 32'(frozen), 32'h1);
        chk("frz_hit_disp0", 32'(disp0), 32'h1000);

        // Release
        freeze_clr = 1'b1;
        tick(1);
        freeze_clr = 1'b0;
        chk("clr_frozen", 32'(frozen), 32'h0);
        chk("clr_disp0", 32'(disp0), 32'hFFFF);
        chk("clr_disp1", 32'(disp1), 32'hFFFF);

        // Hit and freeze_clr together in LIVE
        pc = 16'h0040;
        freeze_clr = 1'b1;
        tick(1);
        pc = 16'h0000;
        freeze_clr = 1'b0;
        chk("sim_frozen", 32'(frozen), 32'h0);
        chk("sim_hits", 32'(hit_count), 32'd3);
        tick(1);
        chk("sim_frozen_after", 32'(frozen), 32'h0);

        // Freeze again, scroll in AUTO, then async reset between edges
        ch_data = ramp_channels();
        pc = 16'h0040;
        tick(1);
        pc = 16'h0000;
        chk("refrz_frozen", 32'(frozen), 32'h1);
        chk("refrz_hits", 32'(hit_count), 32'd4);
        ch_data = '1;
        mode = VIEW_AUTO;
        tick(4);
        chk("frz_auto_pair", 32'(pair_idx), 32'd1);
        chk("frz_auto_disp1", 32'(disp1), 32'h1003);
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst_disp1", 32'(disp1), 32'h0);
        chk("arst_disp0", 32'(disp0), 32'h0);
        chk("arst_pair", 32'(pair_idx), 32'h0);
        chk("arst_frozen", 32'(frozen), 32'h0);
        chk("arst_hits", 32'(hit_count), 32'h0);
        mode = VIEW_MANUAL;
        sel_pair = 2'd0;
        @(negedge clock);
        reset_L = 1'b1;
        tick(1);
        chk("post_rst_frozen", 32'(frozen), 32'h0);
        chk("post_rst_disp0", 32'(disp0), 32'hFFFF);
        chk("post_rst_hits", 32'(hit_count), 32'h0);

        // Saturation
        pc = 16'h0040;
        tick(65534);
        chk("sat_fffe", 32'(hit_count), 32'hFFFE);
        tick(1);
        chk("sat_ffff", 32'(hit_count), 32'hFFFF);
        tick(3);
        chk("sat_hold", 32'(hit_count), 32'hFFFF);
        pc = 16'h0000;
        freeze_clr = 1'b1;
        tick(1);
        freeze_clr = 1'b0;
        chk("sat_clr_keeps", 32'(hit_count), 32'hFFFF);
        chk("sat_clr_frozen", 32'(frozen), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
